// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_stall_ctrl_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned STALL_W     = 32;
    localparam int unsigned MUL_CYC_DEF = 4;
    localparam int unsigned DIV_CYC_DEF = 32;
    localparam int unsigned CNT_W_DEF   = 6;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MDU = 1'b1
    } state_e;

endpackage : pipe_stall_ctrl_pkg

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use hazard compare between the EX load destination and the ID sources.
module hazard_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    output logic       lu_stall
);

    logic rs_hit;
    logic rt_hit;

    // r0 is hardwired zero, so a load into it never hazards.
    assign rs_hit   = id_use_rs && (id_rs == ex_rd);
    assign rt_hit   = id_use_rt && (id_rt == ex_rd);
    assign lu_stall = ex_is_load && (ex_rd != REG_W'(0)) && (rs_hit || rt_hit);

endmodule : hazard_detect

// File: rtl/pipe_stall_ctrl.sv
// Pipeline register enable/flush sequencer: load-use, branch flush, MDU occupancy, dmem wait.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYC = MUL_CYC_DEF,
    parameter int unsigned DIV_CYC = DIV_CYC_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_mdu,
    input  logic        id_mdu_div,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        br_taken,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_cycles
);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] mdu_load;
    logic             lu_stall;

    hazard_detect u_hazard_detect (
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .lu_stall   (lu_stall)
    );

    assign mdu_load = id_mdu_div ? CNT_W'(DIV_CYC - 1) : CNT_W'(MUL_CYC - 1);

    // State and MDU countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and all enables/flushes.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mdu_busy     = 1'b0;
        mdu_done     = 1'b0;

        if (rst) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (dmem_req && !dmem_ack) begin
                        // whole pipe frozen until memory answers
                    end else if (lu_stall) begin
                        id_ex_en    = 1'b1;
                        id_ex_flush = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                    end else begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if_id_flush = br_taken;
                        if (id_mdu) begin
                            cnt_nxt = mdu_load;
                            if (mdu_load != '0) begin
                                state_nxt = ST_MDU;
                            end
                        end
                    end
                end
                ST_MDU: begin
                    mdu_busy = 1'b1;
                    if (cnt != '0) begin
                        // front end held; MEM/WB drain behind a bubble
                        ex_mem_en    = 1'b1;
                        ex_mem_flush = 1'b1;
                        mem_wb_en    = 1'b1;
                        cnt_nxt      = cnt - CNT_W'(1);
                    end else begin
                        mdu_done  = 1'b1;
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Saturating count of PC-stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != {STALL_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule : pipe_stall_ctrl

// File: tb/tb_pipe_stall_ctrl.sv
// Directed plus randomized bench for pipe_stall_ctrl against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_use_rs, id_use_rt, id_mdu, id_mdu_div, ex_is_load;
    logic        br_taken, dmem_req, dmem_ack;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic        mdu_busy, mdu_done;
    logic [31:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: is EX occupied by an MDU op, and how many occupied cycles remain
    bit          m_busy = 0;
    int          m_left = 0;
    logic [31:0] m_stall = 0;

    pipe_stall_ctrl #(.MUL_CYC(MUL_N), .DIV_CYC(DIV_N), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_mdu(id_mdu), .id_mdu_div(id_mdu_div),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_mdu = 0; id_mdu_div = 0; ex_is_load = 0; ex_rd = 0;
        br_taken = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    // One clock: settle inputs, compare against the model, then advance the model.
    task automatic cycle(input string tag);
        logic [4:0] e_en;
        logic [2:0] e_fl;
        bit         e_busy, e_done, hz, n_busy;
        int         n_left, occ;
        #2;
        e_en = 5'b00000; e_fl = 3'b000; e_busy = 0; e_done = 0;
        n_busy = m_busy; n_left = m_left;
        hz = ex_is_load && (ex_rd != 0) &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
        if (rst) begin
            n_busy = 0; n_left = 0;
        end else if (m_busy) begin
            e_busy = 1;
            if (m_left > 1) begin
                e_en = 5'b00011; e_fl = 3'b001; n_left = m_left - 1;
            end else begin
                e_en = 5'b11111; e_done = 1; n_busy = 0; n_left = 0;
            end
        end else if (dmem_req && !dmem_ack) begin
            e_en = 5'b00000;
        end else if (hz) begin
            e_en = 5'b00111; e_fl = 3'b010;
        end else begin
            e_en = 5'b11111;
            e_fl = br_taken ? 3'b100 : 3'b000;
            if (id_mdu) begin
                occ = id_mdu_div ? DIV_N : MUL_N;
                if (occ > 1) begin
                    n_busy = 1; n_left = occ;
                end
            end
        end
        chk({tag, ".en"},    32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(e_en));
        chk({tag, ".flush"}, 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'(e_fl));
        chk({tag, ".busy"},  32'(mdu_busy), 32'(e_busy));
        chk({tag, ".done"},  32'(mdu_done), 32'(e_done));
        chk({tag, ".stall"}, stall_cycles, m_stall);
        @(posedge clk);
        if (rst) m_stall = 0;
        else if (!e_en[4] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        m_busy = n_busy; m_left = n_left;
        #1;
    endtask

    logic [31:0] s0;

    initial begin
        idle();
        // reset held over an MDU request
        rst = 1; id_mdu = 1;
        cycle("rst0");
        cycle("rst1");
        idle();
        cycle("post_rst");
        chk("rst_stall_zero", stall_cycles, 32'd0);

        // load-use on rs, then r0 destination
        ex_is_load = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
        cycle("lu_rs");
        idle();
        cycle("lu_after");
        ex_is_load = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
        cycle("lu_r0");
        idle();
        ex_is_load = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1; id_rs = 9; id_use_rs = 0;
        cycle("lu_rt");
        idle();

        // MUL occupancy
        s0 = stall_cycles;
        id_mdu = 1; id_mdu_div = 0;
        cycle("mul_issue");
        idle();
        for (int i = 0; i < MUL_N; i++) cycle("mul_occ");
        chk("mul_stall_delta", stall_cycles - s0, 32'd3);
        cycle("mul_after");

        // DIV interrupted by reset at cycle 10
        id_mdu = 1; id_mdu_div = 1;
        cycle("div_issue");
        idle();
        for (int i = 1; i < 10; i++) cycle("div_occ");
        rst = 1;
        cycle("div_rst");
        rst = 0;
        cycle("div_resume");
        chk("div_resume_pc_en", 32'(pc_en), 32'd1);

        // memory wait 5 cycles then ack
        dmem_req = 1;
        for (int i = 0; i < 5; i++) cycle("mem_wait");
        dmem_ack = 1;
        cycle("mem_ack");
        idle();

        // load-use beats branch, branch honoured on re-present
        ex_is_load = 1; ex_rd = 7; id_rs = 7; id_use_rs = 1; br_taken = 1;
        cycle("lu_br");
        ex_is_load = 0;
        cycle("br_after_lu");
        idle();

        // MDU together with branch
        id_mdu = 1; br_taken = 1;
        cycle("mul_br");
        idle();
        for (int i = 0; i < MUL_N; i++) cycle("mul_br_occ");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            id_rs      = 5'($urandom_range(0, 7));
            id_rt      = 5'($urandom_range(0, 7));
            ex_rd      = 5'($urandom_range(0, 7));
            id_use_rs  = 1'($urandom);
            id_use_rt  = 1'($urandom);
            ex_is_load = 1'($urandom);
            id_mdu     = ($urandom_range(0, 15) == 0);
            id_mdu_div = ($urandom_range(0, 3) == 0);
            br_taken   = ($urandom_range(0, 3) == 0);
            dmem_req   = ($urandom_range(0, 2) == 0);
            dmem_ack   = 1'($urandom);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pipe_stall_ctrl
